// File: rtl/stream_pipe_pkg.sv
// Shared types and sizing helpers for the stream_pipe moving-average pipeline.
package stream_pipe_pkg;

    // Upper bounds for the stage-entry fields; instances use the low WIDTH / CH_W bits.
    localparam int unsigned SP_MAX_WIDTH = 128;
    localparam int unsigned SP_MAX_CH_W  = 16;

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [SP_MAX_WIDTH-1:0] data;
        logic [SP_MAX_CH_W-1:0]  ch;
    } stage_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with occupancy, full/empty flags and a synchronous flush.
module stream_fifo
    import stream_pipe_pkg::*;
#(
    parameter int unsigned PW    = 33,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [PW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [PW-1:0] rdata_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    // A push into a full FIFO is legal when the same edge pops.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_pipe.sv
// Per-channel TAPS-point moving average feeding a credit-controlled output FIFO.
// Define STREAM_PIPE_ROUND_EN to round half up instead of truncating the average.
module stream_pipe
    import stream_pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAPS      = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned AFULL_LVL = DEPTH - 2,
    localparam int unsigned CH_W     = ch_width(NUM_CH),
    localparam int unsigned LW       = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]  in_ch,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             full,
    output logic             empty
);

    localparam int unsigned SH = $clog2(TAPS);
    localparam int unsigned SW = WIDTH + SH;

    logic [WIDTH-1:0] hist_q [NUM_CH][TAPS-1];
    logic [WIDTH-1:0] hist_d [NUM_CH][TAPS-1];
    stage_t           stage_q, stage_d;
    logic             stage_vld_q, stage_vld_d;

    logic             ch_ok, accept;
    logic [CH_W-1:0]  ch_idx;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] result;
    logic [LW-1:0]    fifo_level;
    logic             fifo_empty, fifo_full;
    logic [WIDTH+CH_W-1:0] fifo_rdata;
    logic             unused_stage;

    assign ch_ok  = (32'(in_ch) < NUM_CH);
    assign ch_idx = ch_ok ? in_ch : '0;

    // Reserving a slot for the staged entry guarantees its FIFO push never stalls.
    assign in_ready = !rst && !flush && ((32'(fifo_level) + 32'(stage_vld_q)) < DEPTH);
    assign accept   = in_valid && in_ready && ch_ok;

    always_comb begin
        sum = SW'(in_data);
        for (int unsigned k = 0; k < TAPS - 1; k++) begin
            sum = sum + SW'(hist_q[ch_idx][k]);
        end
    end

`ifdef STREAM_PIPE_ROUND_EN
    logic [SW:0] sum_rnd;
    logic        unused_rnd_msb;
    assign sum_rnd        = {1'b0, sum} + (SW+1)'(TAPS / 2);
    assign result         = sum_rnd[SH +: WIDTH];
    assign unused_rnd_msb = sum_rnd[SW];
`else
    assign result = sum[SH +: WIDTH];
`endif

    always_comb begin
        hist_d = hist_q;
        if (flush) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < TAPS - 1; k++) begin
                    hist_d[c][k] = '0;
                end
            end
        end else if (accept) begin
            hist_d[ch_idx][0] = in_data;
            for (int unsigned k = 1; k < TAPS - 1; k++) begin
                hist_d[ch_idx][k] = hist_q[ch_idx][k-1];
            end
        end
    end

    always_comb begin
        stage_d     = stage_q;
        stage_vld_d = 1'b0;
        if (accept) begin
            stage_d.data = SP_MAX_WIDTH'(result);
            stage_d.ch   = SP_MAX_CH_W'(in_ch);
            stage_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned k = 0; k < TAPS - 1; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
        end
    end

    assign unused_stage = ^stage_q;

    stream_fifo #(
        .PW    (WIDTH + CH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (stage_vld_q),
        .wdata_i ({stage_q.ch[CH_W-1:0], stage_q.data[WIDTH-1:0]}),
        .pop_i   (out_valid && out_ready),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_data    = fifo_rdata[WIDTH-1:0];
    assign out_ch      = fifo_rdata[WIDTH +: CH_W];
    assign out_valid   = !fifo_empty;
    assign level       = fifo_level;
    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign almost_full = (32'(fifo_level) >= AFULL_LVL);

endmodule

// File: tb/tb_stream_pipe.sv
// Directed self-checking bench for stream_pipe (default parameters) and its FIFO.
module tb_stream_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic [0:0]  in_ch;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [0:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        almost_full;
    logic        full;
    logic        empty;

    logic        f_flush, f_push, f_pop;
    logic [7:0]  f_wdata, f_rdata;
    logic [3:0]  f_level;
    logic        f_full, f_empty;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] cap_d[$];
    logic [0:0]  cap_c[$];
    logic [31:0] exp_d[$];
    logic [0:0]  exp_c[$];

    stream_pipe #(
        .WIDTH     (32),
        .TAPS      (4),
        .DEPTH     (8),
        .NUM_CH    (2),
        .AFULL_LVL (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_data     (in_data),
        .in_ch       (in_ch),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full),
        .full        (full),
        .empty       (empty)
    );

    stream_fifo #(
        .PW    (8),
        .DEPTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (f_flush),
        .push_i  (f_push),
        .wdata_i (f_wdata),
        .pop_i   (f_pop),
        .rdata_o (f_rdata),
        .level_o (f_level),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every entry that will pop on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_c.push_back(out_ch);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        cap_d.delete();
        cap_c.delete();
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [0:0] c);
        exp_d.push_back(d);
        exp_c.push_back(c);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, 64'(cap_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            check_eq({tag, "_data"}, 64'(cap_d[i]), 64'(exp_d[i]));
            check_eq({tag, "_ch"}, 64'(cap_c[i]), 64'(exp_c[i]));
        end
        exp_d.delete();
        exp_c.delete();
    endtask

    initial begin
        int exp_lvl;
        int exp_sv;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = 1'b0;
        out_ready = 1'b0; f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
        step();
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        check_eq("rst_out_ch", 64'(out_ch), 64'(0));
        check_eq("rst_level", 64'(level), 64'(0));
        check_eq("rst_empty", 64'(empty), 64'(1));
        check_eq("rst_full", 64'(full), 64'(0));
        check_eq("rst_afull", 64'(almost_full), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 64'(in_ready), 64'(1));

        // ch0 constant 8: ramp 2,4,6,8 with two-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 1'b0; in_data = 32'd8;
        step();
        check_eq("lat_n_valid", 64'(out_valid), 64'(0));
        step();
        check_eq("lat_n1_valid", 64'(out_valid), 64'(1));
        check_eq("lat_n1_data", 64'(out_data), 64'(2));
        repeat (2) step();
        in_valid = 1'b0;
        repeat (4) step();
        expect_out(32'd2, 1'b0); expect_out(32'd4, 1'b0);
        expect_out(32'd6, 1'b0); expect_out(32'd8, 1'b0);
        check_stream("avg8");

        // interleaved channels
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ch    = 1'(i % 2);
            in_data  = (i % 2 == 1) ? 32'd40 : 32'd100;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        expect_out(32'd25, 1'b0); expect_out(32'd10, 1'b1);
        expect_out(32'd50, 1'b0); expect_out(32'd20, 1'b1);
        expect_out(32'd75, 1'b0); expect_out(32'd30, 1'b1);
        expect_out(32'd100, 1'b0); expect_out(32'd40, 1'b1);
        check_stream("ilv");

        // back-pressure fill, credit drop, single pop, wrap
        do_reset();
        in_valid = 1'b1; in_ch = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) in_data = 32'(4 * k);
            step();
            exp_lvl = k - 1;
            exp_sv  = (k <= 8) ? 1 : 0;
            check_eq("fill_level", 64'(level), 64'(exp_lvl));
            check_eq("fill_ready", 64'(in_ready), 64'((exp_lvl + exp_sv) < 8));
            check_eq("fill_afull", 64'(almost_full), 64'(exp_lvl >= 6));
            check_eq("fill_full", 64'(full), 64'(exp_lvl == 8));
        end
        in_data   = 32'd36;
        out_ready = 1'b1;
        check_eq("full_head", 64'(out_data), 64'(1));
        step();
        check_eq("pop_level", 64'(level), 64'(7));
        check_eq("pop_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check_eq("pp_level", 64'(level), 64'(6));
        repeat (10) step();
        expect_out(32'd1, 1'b0);  expect_out(32'd3, 1'b0);  expect_out(32'd6, 1'b0);
        expect_out(32'd10, 1'b0); expect_out(32'd14, 1'b0); expect_out(32'd18, 1'b0);
        expect_out(32'd22, 1'b0); expect_out(32'd26, 1'b0); expect_out(32'd30, 1'b0);
        check_stream("wrap");

        // FIFO alone: push+pop at level 8 and ordering across wrap
        f_push = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f_wdata = 8'(i + 1);
            step();
        end
        check_eq("f_full", 64'(f_full), 64'(1));
        check_eq("f_level8", 64'(f_level), 64'(8));
        f_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_wdata = 8'(9 + i);
            check_eq("f_pp_head", 64'(f_rdata), 64'(i + 1));
            step();
            check_eq("f_pp_level", 64'(f_level), 64'(8));
        end
        f_push = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("f_drain", 64'(f_rdata), 64'(5 + i));
            step();
        end
        f_pop = 1'b0;
        check_eq("f_empty", 64'(f_empty), 64'(1));
        check_eq("f_level0", 64'(f_level), 64'(0));

        // flush with level 5 and a staged entry
        do_reset();
        in_valid = 1'b1; in_ch = 1'b0; in_data = 32'd8;
        repeat (6) step();
        check_eq("pre_flush_level", 64'(level), 64'(5));
        flush = 1'b1;
        #1;
        check_eq("flush_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0;
        check_eq("flush_level", 64'(level), 64'(0));
        check_eq("flush_empty", 64'(empty), 64'(1));
        check_eq("flush_valid", 64'(out_valid), 64'(0));
        step();
        in_valid = 1'b0;
        check_eq("post_flush_stage", 64'(level), 64'(0));
        step();
        check_eq("post_flush_valid", 64'(out_valid), 64'(1));
        check_eq("post_flush_data", 64'(out_data), 64'(2));

        // reset mid-operation drops everything
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_level", 64'(level), 64'(0));
        check_eq("midrst_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_data", 64'(out_data), 64'(0));
        check_eq("midrst_ready", 64'(in_ready), 64'(0));
        step();
        rst = 1'b0;
        #1;
        check_eq("midrst_rel_ready", 64'(in_ready), 64'(1));
        repeat (2) step();
        check_eq("midrst_no_stale", 64'(out_valid), 64'(0));

        // rounding vs truncation
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 1'b0; in_data = 32'd3;
        step();
        in_valid = 1'b0;
        step();
        check_eq("small_valid", 64'(out_valid), 64'(1));
`ifdef STREAM_PIPE_ROUND_EN
        check_eq("small_result", 64'(out_data), 64'(1));
`else
        check_eq("small_result", 64'(out_data), 64'(0));
`endif

        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_ch = 1'b0; in_data = '1;
        repeat (4) step();
        in_valid = 1'b0;
        repeat (4) step();
`ifdef STREAM_PIPE_ROUND_EN
        expect_out(32'h4000_0000, 1'b0); expect_out(32'h8000_0000, 1'b0);
`else
        expect_out(32'h3FFF_FFFF, 1'b0); expect_out(32'h7FFF_FFFF, 1'b0);
`endif
        expect_out(32'hBFFF_FFFF, 1'b0); expect_out(32'hFFFF_FFFF, 1'b0);
        check_stream("ones");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_pipe.md
STREAM_PIPE -- requirements
Module: stream_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: sample width in bits.
REQ-002 The block SHALL have parameter TAPS, default 4: moving-average length, power of 2, >=2.
REQ-003 The block SHALL have parameter DEPTH, default 8: output FIFO entries, power of 2, >=2.
REQ-004 The block SHALL have parameter NUM_CH, default 2: independent interleaved channels, >=1.
REQ-005 The block SHALL have parameter AFULL_LVL, default DEPTH-2: almost_full threshold.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous reset, active high).
REQ-007 The block SHALL have these ports: flush input 1 (synchronous clear); in_data input WIDTH (sample); in_ch input CH_W (channel id, CH_W = max(1, clog2(NUM_CH))); in_valid input 1; in_ready output 1.
REQ-008 The block SHALL have these ports: out_data output WIDTH; out_ch output CH_W; out_valid output 1; out_ready input 1; level output clog2(DEPTH)+1 (FIFO occupancy); almost_full output 1; full output 1; empty output 1.

Function
REQ-009 The block SHALL accept a sample on any rising edge with in_valid && in_ready; the block SHALL sample in_ch and SHALL ignore values >= NUM_CH (no accept, in_ready unaffected).
REQ-010 Per channel, the block SHALL keep the previous TAPS-1 accepted samples; an accept SHALL compute sum = in_data + those samples at WIDTH+clog2(TAPS) bits unsigned, result = sum >> clog2(TAPS), truncated to WIDTH.
REQ-011 An accept SHALL shift only the addressed channel's history; other channels SHALL be untouched.
REQ-012 The result and its channel id SHALL be held in a one-entry stage register on the accepting edge N, written to the FIFO on edge N+1, and visible as out_valid=1 after edge N+1 if the FIFO was empty (latency 2).
REQ-013 in_ready SHALL equal !rst && !flush && (level + stage_valid < DEPTH), so a stage write is never blocked.
REQ-014 out_valid SHALL equal !empty; an entry SHALL pop on out_valid && out_ready; out_data/out_ch SHALL be held stable while out_valid && !out_ready.
REQ-015 Simultaneous push and pop SHALL leave level unchanged, including at level DEPTH; FIFO pointers SHALL wrap modulo DEPTH.
REQ-016 full SHALL equal (level == DEPTH), empty SHALL equal (level == 0), and almost_full SHALL equal (level >= AFULL_LVL).
REQ-017 flush SHALL, on the same edge, empty the FIFO, clear stage_valid and zero all channel histories; any pop or accept presented that cycle SHALL be discarded.

Reset
REQ-018 While rst is high, the block SHALL hold out_valid=0, out_data=0, out_ch=0, level=0, empty=1, full=0, almost_full=0 and in_ready=0, and SHALL zero all histories and the stage register.
REQ-019 Reset asserted mid-operation SHALL drop all in-flight and buffered data, and in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-020 With macro STREAM_PIPE_ROUND_EN defined, result SHALL be (sum + TAPS/2) >> clog2(TAPS) (round half up, sum widened by 1 bit, then truncated to WIDTH); without it, the block SHALL truncate per REQ-010.

Structure
REQ-021 Package stream_pipe_pkg SHALL hold the CH_W/level-width helper functions and the stage-entry struct (data, ch).
REQ-022 The FIFO SHALL be sub-module stream_fifo (WIDTH+CH_W payload, DEPTH, level/full/empty outputs, flush input); filter and credit logic SHALL live in stream_pipe.

Verification
REQ-023 The bench SHALL check: after reset, with TAPS=4 and ch0 inputs 8,8,8,8, out_data SHALL be 2,4,6,8 in order, and first out_valid SHALL occur 2 cycles after the first accept.
REQ-024 The bench SHALL check: interleaved ch0=100 and ch1=40 samples (×4 each) SHALL give ch0 outputs 25,50,75,100 and ch1 outputs 10,20,30,40, with no cross-channel mixing.
REQ-025 The bench SHALL check: with out_ready=0 and continuous input, in_ready SHALL drop exactly when level+stage_valid=8, level SHALL reach 8, full=1 and almost_full SHALL rise at level 6; one pop SHALL then re-raise in_ready next cycle.
REQ-026 The bench SHALL check: at level 8 with push and pop on the same edge, level SHALL stay 8, and ordering SHALL be preserved across the pointer wrap.
REQ-027 The bench SHALL check: flush with level=5 and stage_valid=1 SHALL give level=0 and empty=1 next cycle, and the next input 8 on ch0 SHALL give output 2.
REQ-028 The bench SHALL check: a single ch0 input of 3 from zero history SHALL output 0 without STREAM_PIPE_ROUND_EN and 1 with it, and an all-ones input ×4 SHALL output all-ones in both builds.
